// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO popped with a valid/ready handshake.
// Define UART_RX_MAJORITY_EN to take each bit as a 3-sample majority vote around the tick.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 9
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [15:0]      DIV,
  input  logic             RXD,
  output logic [7:0]       RX_DATA,
  output logic             RX_VALID,
  input  logic             RX_READY,
  output logic [CNT_W-1:0] RX_COUNT,
  output logic             RX_BUSY,
  output logic             FRAME_ERR,
  output logic             OVERRUN,
  input  logic             CLR_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

`ifdef UART_RX_MAJORITY_EN
  localparam int FILL_W = 3;
`else
  localparam int FILL_W = 2;
`endif

  // ---------------------------------------------------------------- input sampling
  logic              sync1_q;
  logic              rxs_q;
  logic              prev_q;
  logic [FILL_W-1:0] fill_q;
  logic              armed_q;
  logic              sample;
  logic              cur_bit;
  logic              last_bit;
  logic              cur_real;

`ifdef UART_RX_MAJORITY_EN
  logic prev2_q;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) prev2_q <= 1'b1;
    else     prev2_q <= prev_q;
  end

  // Vote is centred on prev_q, so the whole schedule runs one cycle behind rxs.
  assign sample   = (prev2_q & prev_q) | (prev2_q & rxs_q) | (prev_q & rxs_q);
  assign cur_bit  = prev_q;
  assign last_bit = prev2_q;
`else
  assign sample   = rxs_q;
  assign cur_bit  = rxs_q;
  assign last_bit = prev_q;
`endif
  assign cur_real = fill_q[FILL_W-1];

  // The flops reset to 1, so a start is only trusted once real line data shows high.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= RXD;
      rxs_q   <= sync1_q;
      prev_q  <= rxs_q;
      fill_q  <= {fill_q[FILL_W-2:0], 1'b1};
      armed_q <= armed_q | (cur_real & cur_bit);
    end
  end

  // ---------------------------------------------------------------- receive FSM
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        busy_q;
  logic        frame_err_q;
  logic [15:0] div_eff;
  logic        tick;
  logic        fall;
  logic        push_req;

  assign div_eff  = (DIV < 16'd3) ? 16'd3 : DIV;
  assign tick     = (cnt_q == 16'd0);
  assign fall     = armed_q & last_bit & ~cur_bit;
  assign push_req = (state_q == S_STOP) & tick & sample;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
      case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_q <= S_START;
            cnt_q   <= div_eff >> 1;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            if (!sample) begin
              state_q   <= S_DATA;
              cnt_q     <= div_eff;
              bit_cnt_q <= 3'd0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q   <= {sample, shift_q[7:1]};
            cnt_q     <= div_eff;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (sample) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q     <= S_BREAK;
              frame_err_q <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (sample) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- receive FIFO
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        overrun_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = RX_READY & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push  = push_req & (~full | pop);
  assign count = wr_q - rd_q;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      wr_q      <= '0;
      rd_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push_req && full && !pop) overrun_q <= 1'b1;
      else if (CLR_ERR)             overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_q[AW-1:0]] <= shift_q;
  end

  assign RX_DATA   = empty ? 8'h00 : mem[rd_q[AW-1:0]];
  assign RX_VALID  = ~empty;
  assign RX_COUNT  = CNT_W'(count);
  assign RX_BUSY   = busy_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable UART receiver (8N1) with a receive FIFO, downstream of the board UART_RXD pin inside the FPGA top.
- Turns the serial stream into bytes that the bfCPU input path pops with a valid/ready handshake.
- Bit timing comes from a run-time divider value so the simulation and 115200 bps settings share one RTL.

Parameters:
- FIFO_DEPTH, 16, number of byte entries; power of two, 2..256.
- CNT_W, 9, width of the RX_COUNT output; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RES  in  1  asynchronous, active-high reset.
- DIV  in  16  bit period in CLK cycles minus 1; values below 3 are treated as 3.
- RXD  in  1  serial input, asynchronous to CLK, idle high.
- RX_DATA  out  8  FIFO head byte; meaningful only while RX_VALID=1.
- RX_VALID  out  1  FIFO not empty.
- RX_READY  in  1  consumer pops the head when RX_VALID and RX_READY are both 1.
- RX_COUNT  out  CNT_W  current FIFO occupancy.
- RX_BUSY  out  1  high from start-bit detect until the FSM returns to IDLE.
- FRAME_ERR  out  1  one-cycle pulse when a stop bit samples 0.
- OVERRUN  out  1  sticky; byte dropped because the FIFO was full.
- CLR_ERR  in  1  clears OVERRUN; if an overrun occurs in the same cycle, set wins.

Behaviour:
- Reset values: RX_VALID=0, RX_COUNT=0, RX_BUSY=0, FRAME_ERR=0, OVERRUN=0, RX_DATA=0.
- Reset also sets the FSM to IDLE, empties the FIFO and sets both synchronizer flops and the previous-sample flop to 1.
- Reset mid-frame discards the partial byte. No start is detected until RXD has been seen high and then falls.
- Synchronizer: RXD passes through 2 flops; rxs is the synchronized value.
- Bit counter: loaded with a value, counts down by 1 per cycle; "tick" means the counter is 0, and the counter reloads on that tick.
- DIV is sampled only at each reload, so a change mid-frame takes effect from the next bit.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on falling edge of rxs (previous=1, current=0) go to START, load DIV>>1, set RX_BUSY.
  - START: on tick, if rxs=0 go to DATA and load DIV. If rxs=1 it is a false start: return to IDLE, no error.
  - DATA: on each tick, shift rxs into the shift register LSB-first and load DIV; after the 8th sample go to STOP.
  - STOP: on tick, if rxs=1 push the byte and go to IDLE. If rxs=0, pulse FRAME_ERR, discard the byte and go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. This prevents a held-low line from re-triggering.
- RX_BUSY=0 in IDLE only.
- FIFO uses read/write pointers with an extra wrap bit. Full when the MSBs differ and the other bits are equal; pointers wrap modulo 2·FIFO_DEPTH.
- RX_DATA is the head entry, combinational from storage. RX_VALID rises on the cycle after the push edge.
- Push while full: the byte is dropped and OVERRUN is set.
- Push while full with a pop in the same cycle: the push is accepted, count stays FIFO_DEPTH, OVERRUN is not set.
- Push and pop in the same cycle when non-full: count is unchanged.
- Pop with RX_VALID=0 is ignored.
- Latency from RXD falling edge to the push edge is 2 + ((DIV>>1)+1) + 9·(DIV+1) cycles. With DIV=31 that is 306 cycles.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each sample is the majority of rxs at tick-1, tick and tick+1. The decision moves one cycle later, so all loads are shifted +1 cycle and total latency grows by 1 cycle.
  - A single-cycle glitch on RXD during any bit does not corrupt the data.
  - A 1-cycle low glitch in IDLE causes a false start that is rejected silently.
- Not defined: a single sample at the tick.

Test Plan:
- DIV=31, send 0x55 (bits 32 cycles wide) -> RX_VALID rises at 307±1 cycles after the falling edge, RX_DATA=0x55; RX_READY=1 pops it -> RX_COUNT 1→0.
- DIV=31, send 0x02..0x11 back-to-back (16 bytes) with RX_READY=0 -> RX_COUNT=16, OVERRUN=0. Send 0x12 -> OVERRUN=1, and the pop order reads 0x02..0x11 (0x12 lost). CLR_ERR=1 -> OVERRUN=0.
- Send 0xA3 with the stop bit driven 0, then hold RXD low for 100 cycles -> one FRAME_ERR pulse, RX_COUNT=0, no new start until RXD returns high. Then send 0x41 -> RX_DATA=0x41.
- FIFO full, then push and pop in the same cycle -> RX_COUNT stays 16, OVERRUN stays 0, and the new byte is the last one popped.
- Assert RES midway through byte 0x7E, release it with RXD low -> no byte pushed and RX_BUSY=0 until RXD goes high and falls. Next byte 0x33 is received correctly.
- With UART_RX_MAJORITY_EN: inject a 1-cycle inverted glitch at the centre of bit 3 of 0x0F -> RX_DATA=0x0F. Without the macro the same stimulus -> 0x07.
